// File: rtl/icache_req_rr_arbiter.sv
// Round-robin arbiter sharing one icache request channel among N_REQ
// requesters; a grant stays locked until its handshake completes.
module icache_req_rr_arbiter #(
  parameter type PLD_TYPE = logic,
  parameter int  N_REQ    = 4,
  parameter int  ID_W     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] s_vld,
  output logic [N_REQ-1:0] s_rdy,
  input  PLD_TYPE          s_pld [N_REQ],
  output logic             m_vld,
  input  logic             m_rdy,
  output PLD_TYPE          m_pld,
  output logic [ID_W-1:0]  m_id,
  output logic             busy
);

  typedef logic [ID_W-1:0] id_t;

  typedef enum logic {
    IDLE,
    LOCKED
  } st_t;

  st_t  st;
  id_t  ptr;
  id_t  lock_id;

  id_t  win;
  id_t  sel_id;
  logic any_vld;
  logic locked;
  int   idx;

  function automatic id_t nxt_id(input id_t id);
    if (int'(id) == N_REQ - 1) begin
      nxt_id = '0;
    end else begin
      nxt_id = id + id_t'(1);
    end
  endfunction

  assign any_vld = |s_vld;

  // While reset is asserted the outputs follow the idle rules,
  // even if the registered state is still LOCKED.
  assign locked = (st == LOCKED) && rst_n;

  always_comb begin
    win = ptr;
    idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (s_vld[idx]) begin
        win = id_t'(idx);
      end
    end
  end

  always_comb begin
    sel_id = win;
    m_vld  = any_vld;
    if (locked) begin
      sel_id = lock_id;
      m_vld  = s_vld[lock_id];
    end
  end

  assign m_id  = sel_id;
  assign m_pld = s_pld[sel_id];

  always_comb begin
    s_rdy = '0;
    if (locked) begin
      s_rdy[lock_id] = m_rdy;
    end else begin
      s_rdy[win] = m_rdy & any_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= IDLE;
      ptr     <= '0;
      lock_id <= '0;
      busy    <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (any_vld) begin
            if (m_rdy) begin
              ptr <= nxt_id(win);
            end else begin
              st      <= LOCKED;
              lock_id <= win;
              busy    <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (m_rdy) begin
            st   <= IDLE;
            ptr  <= nxt_id(lock_id);
            busy <= 1'b0;
          end
        end
        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

  a_rdy_onehot: assert property (
    @(posedge clk) $onehot0(s_rdy)
  ) else $error("s_rdy not one-hot");

  a_lock_vld: assert property (
    @(posedge clk) disable iff (!rst_n)
    (st == LOCKED) |-> s_vld[lock_id]
  ) else $error("locked requester dropped vld");

  a_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (m_vld && !m_rdy) |=> ($stable(m_id) && $stable(m_pld))
  ) else $error("m_pld/m_id changed while stalled");

endmodule
